johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 4-bit `johnsoncounter` output. It decodes each Johnson code into a registered phase index and a one-hot phase strobe. It also checks that the code stream is legal and advances one step at a time, and counts completed rotations. It sits directly behind the counter on the same clock and feeds phase-sequenced logic that needs clean one-hot enables plus a health flag.

## Interface
- `JC_W`, 4, Johnson counter width; phases `NPH = 2*JC_W`.
- `CNT_W`, 8, width of the rotation counter.
- `clk`  in  1  rising-edge clock, shared with `johnsoncounter`.
- `reset`  in  1  asynchronous, active-high reset.
- `jc_in`  in  `JC_W`  Johnson code from the counter's `out`.
- `err_clr`  in  1  single-cycle request to leave ERROR.
- `phase_idx`  out  `$clog2(NPH)`  decoded phase index, 0..`NPH-1`.
- `phase_oh`  out  `NPH`  one-hot phase strobe, `phase_oh[phase_idx]` set when valid.
- `valid`  out  1  outputs track a locked, legal stream.
- `wrap`  out  1  one-cycle pulse on phase `NPH-1` -> 0.
- `rot_cnt`  out  `CNT_W`  completed rotations, modulo 2^`CNT_W`.
- `err_illegal`  out  1  sticky: non-Johnson code seen while LOCKED.
- `err_step`  out  1  sticky: legal but non-adjacent step seen while LOCKED.

## Operation
- Johnson sequence (left shift, `~msb` into lsb): index k ≤ `JC_W` is the low k bits set; index k > `JC_W` is the top `NPH-k` bits set. For `JC_W`=4: 0000,0001,0011,0111,1111,1110,1100,1000 = idx 0..7. The other 2^`JC_W`-`NPH` codes are illegal.
- FSM states: SYNC, LOCKED, ERROR. Reset state is SYNC.
- SYNC: `valid`=0, `phase_oh`=0.
  - Legal `jc_in` -> LOCKED. Load `phase_idx`, set `valid`=1, drive `phase_oh`.
  - Illegal `jc_in` -> stay in SYNC. No error flags are set.
- LOCKED: let p be the held index and k the decoded index of `jc_in`.
  - k == p (counter stalled): hold all outputs.
  - k == (p+1) mod `NPH`: advance to k.
  - If that advance is p=`NPH-1` -> k=0: `wrap`=1 for one cycle and `rot_cnt` += 1. `rot_cnt` wraps at all-ones to 0; no saturation.
  - Illegal code -> ERROR with `err_illegal`=1.
  - Any other legal k (backward or skip) -> ERROR with `err_step`=1.
- ERROR: `valid`=0, `phase_oh`=0, `phase_idx` holds its last value, and both error flags stay sticky. `rot_cnt` holds.
  - `err_clr`=1 -> SYNC. Clears both error flags. `rot_cnt` is not cleared.
  - `err_clr` in SYNC or LOCKED has no effect.
- Simultaneous events: `err_clr` in ERROR always goes to SYNC, never directly to LOCKED, even when `jc_in` is legal. Relock happens one cycle later.
- Only reset clears `rot_cnt`.

## Timing
- Latency is 1 cycle: the outputs after rising edge t reflect `jc_in` sampled at edge t. There is no combinational path from input to output.
- `wrap` is high for exactly one cycle per rotation and is never high outside LOCKED.
- Reset, asynchronous and immediate, including mid-rotation:
  - state=SYNC;
  - `phase_idx`=0, `phase_oh`=0, `valid`=0;
  - `wrap`=0, `rot_cnt`=0;
  - `err_illegal`=0, `err_step`=0.
- The upstream counter reset to 0000 is legal idx 0. The decoder therefore locks on the first edge after reset deassertion and shows `phase_oh`=0000_0001.
- The error flags rise in the same cycle that ERROR is entered and fall in the cycle after `err_clr` is sampled.

## Structure
- Package `johnson_pkg` holds:
  - default `JC_W`;
  - state encodings `ST_SYNC`=2'd0, `ST_LOCKED`=2'd1, `ST_ERROR`=2'd2;
  - a code->index/legal function shared with benches.
- Sub-module `johnson_code_check` is purely combinational. It takes `jc_in` and produces `legal` and `idx`. The top level holds the FSM, the output registers and `rot_cnt`.

## Test plan
- Reset for 2 cycles, then drive 0000,0001,0011,0111,1111,1110,1100,1000,0000 -> `valid`=1 from the first edge; `phase_idx` 0..7,0; `wrap`=1 only on the 7->0 cycle; `rot_cnt`=1.
- While LOCKED at idx 3, inject 0101 -> next cycle: ERROR, `err_illegal`=1, `valid`=0, `phase_oh`=0. Pulse `err_clr` while driving 1111 -> SYNC. Next edge: LOCKED at idx 4.
- While LOCKED at idx 2 (0011), drive 1111 (skip to 4) -> `err_step`=1, `err_illegal`=0. A repeat of 0011 (stall) beforehand must not flag.
- Run 256 rotations with `CNT_W`=8 -> `rot_cnt` reads 0 after the 256th `wrap` and 1 after the 257th.
- Assert reset mid-rotation at idx 5 with `err_step` set -> all outputs zero immediately (before the next edge). After release with 0000: LOCKED at idx 0, flags clear.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types, defaults and the Johnson code decode helper for the phase decoder.
// The FSM encodings are fixed so that benches and debug tools can read the state.
package johnson_pkg;

  localparam int JC_W_DEF  = 4;
  localparam int CNT_W_DEF = 8;
  localparam int NPH_DEF   = 2 * JC_W_DEF;
  localparam int IDX_W_DEF = $clog2(NPH_DEF);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } jpd_state_e;

  typedef struct packed {
    logic                 legal;
    logic [IDX_W_DEF-1:0] idx;
  } jc_dec_t;

  // Index k <= JC_W has the low k bits set; index k > JC_W has the top NPH-k bits set.
  function automatic jc_dec_t jc_decode(input logic [JC_W_DEF-1:0] code);
    jc_dec_t     res;
    logic [31:0] pat;
    res = '0;
    for (int k = 0; k < NPH_DEF; k++) begin
      if (k <= JC_W_DEF) begin
        pat = (32'd1 << k) - 32'd1;
      end else begin
        pat = ((32'd1 << JC_W_DEF) - 32'd1) & ~((32'd1 << (k - JC_W_DEF)) - 32'd1);
      end
      if (code == pat[JC_W_DEF-1:0]) begin
        res.legal = 1'b1;
        res.idx   = IDX_W_DEF'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson code classifier: flags whether a code is one of the
// 2*JC_W legal states and, if so, which phase index it represents.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int JC_W  = JC_W_DEF,
  parameter int NPH   = 2 * JC_W,
  parameter int IDX_W = $clog2(2 * JC_W)
) (
  input  logic [JC_W-1:0]  jc_in,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  logic [JC_W-1:0] w_pat [NPH];

  for (genvar k = 0; k < NPH; k++) begin : g_pat
    if (k <= JC_W) begin : g_low
      assign w_pat[k] = JC_W'((32'd1 << k) - 32'd1);
    end else begin : g_high
      assign w_pat[k] = JC_W'(((32'd1 << JC_W) - 32'd1) & ~((32'd1 << (k - JC_W)) - 32'd1));
    end
  end

  // Patterns are distinct, so at most one entry can match.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int k = 0; k < NPH; k++) begin
      if (jc_in == w_pat[k]) begin
        legal = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Locks onto a Johnson counter stream, emits registered phase index / one-hot
// strobe, counts rotations and latches sticky errors on illegal or skipped steps.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int JC_W  = JC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int NPH   = 2 * JC_W,
  parameter int IDX_W = $clog2(2 * JC_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [JC_W-1:0]  jc_in,
  input  logic             err_clr,
  output logic [IDX_W-1:0] phase_idx,
  output logic [NPH-1:0]   phase_oh,
  output logic             valid,
  output logic             wrap,
  output logic [CNT_W-1:0] rot_cnt,
  output logic             err_illegal,
  output logic             err_step
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPH - 1);
  localparam logic [NPH-1:0]   OH_ONE   = {{(NPH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  jpd_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_phase_idx, w_idx_nxt;
  logic [NPH-1:0]   r_phase_oh, w_oh_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [CNT_W-1:0] r_rot_cnt, w_rot_nxt;
  logic             r_err_illegal, w_ill_nxt;
  logic             r_err_step, w_step_nxt;

  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_idx_plus1;

  johnson_code_check #(
    .JC_W  (JC_W),
    .NPH   (NPH),
    .IDX_W (IDX_W)
  ) u_code_check (
    .jc_in (jc_in),
    .legal (w_legal),
    .idx   (w_idx)
  );

  assign w_idx_plus1 = (r_phase_idx == IDX_LAST) ? {IDX_W{1'b0}} : (r_phase_idx + IDX_W'(1));

  // State and output registers; every output is taken straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SYNC;
      r_phase_idx   <= '0;
      r_phase_oh    <= '0;
      r_valid       <= 1'b0;
      r_wrap        <= 1'b0;
      r_rot_cnt     <= '0;
      r_err_illegal <= 1'b0;
      r_err_step    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase_idx   <= w_idx_nxt;
      r_phase_oh    <= w_oh_nxt;
      r_valid       <= w_valid_nxt;
      r_wrap        <= w_wrap_nxt;
      r_rot_cnt     <= w_rot_nxt;
      r_err_illegal <= w_ill_nxt;
      r_err_step    <= w_step_nxt;
    end
  end

  // Next-state and next-output logic; err_clr always routes ERROR through SYNC.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_phase_idx;
    w_oh_nxt    = r_phase_oh;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;
    w_rot_nxt   = r_rot_cnt;
    w_ill_nxt   = r_err_illegal;
    w_step_nxt  = r_err_step;
    case (r_state)
      ST_SYNC: begin
        if (w_legal) begin
          w_state_nxt = ST_LOCKED;
          w_idx_nxt   = w_idx;
          w_valid_nxt = 1'b1;
          w_oh_nxt    = OH_ONE << w_idx;
        end else begin
          w_valid_nxt = 1'b0;
          w_oh_nxt    = '0;
        end
      end
      ST_LOCKED: begin
        if (!w_legal) begin
          w_state_nxt = ST_ERROR;
          w_ill_nxt   = 1'b1;
          w_valid_nxt = 1'b0;
          w_oh_nxt    = '0;
        end else if (w_idx == r_phase_idx) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_idx == w_idx_plus1) begin
          w_idx_nxt = w_idx;
          w_oh_nxt  = OH_ONE << w_idx;
          if (r_phase_idx == IDX_LAST) begin
            w_wrap_nxt = 1'b1;
            w_rot_nxt  = r_rot_cnt + CNT_ONE;
          end else begin
            w_wrap_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = ST_ERROR;
          w_step_nxt  = 1'b1;
          w_valid_nxt = 1'b0;
          w_oh_nxt    = '0;
        end
      end
      ST_ERROR: begin
        w_valid_nxt = 1'b0;
        w_oh_nxt    = '0;
        if (err_clr) begin
          w_state_nxt = ST_SYNC;
          w_ill_nxt   = 1'b0;
          w_step_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_ERROR;
        end
      end
      default: begin
        w_state_nxt = ST_SYNC;
        w_valid_nxt = 1'b0;
        w_oh_nxt    = '0;
      end
    endcase
  end

  assign phase_idx   = r_phase_idx;
  assign phase_oh    = r_phase_oh;
  assign valid       = r_valid;
  assign wrap        = r_wrap;
  assign rot_cnt     = r_rot_cnt;
  assign err_illegal = r_err_illegal;
  assign err_step    = r_err_step;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: a table-driven behavioural model is
// checked against the DUT every cycle, plus literal expectations at key points.
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] jc_in = 4'b0000;
  logic       err_clr = 1'b0;
  logic [2:0] phase_idx;
  logic [7:0] phase_oh;
  logic       valid;
  logic       wrap;
  logic [7:0] rot_cnt;
  logic       err_illegal;
  logic       err_step;

  int tests = 0;
  int fails = 0;

  // Legal Johnson codes in phase order.
  logic [3:0] tab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  localparam int M_SYNC = 0, M_LOCK = 1, M_ERR = 2;
  int m_st, m_idx, m_rot, m_wrap, m_ill, m_step;

  johnson_phase_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .jc_in       (jc_in),
    .err_clr     (err_clr),
    .phase_idx   (phase_idx),
    .phase_oh    (phase_oh),
    .valid       (valid),
    .wrap        (wrap),
    .rot_cnt     (rot_cnt),
    .err_illegal (err_illegal),
    .err_step    (err_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int lookup(input logic [3:0] code);
    for (int i = 0; i < 8; i++) if (tab[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = M_SYNC; m_idx = 0; m_rot = 0; m_wrap = 0; m_ill = 0; m_step = 0;
  endtask

  task automatic model_update(input logic [3:0] code, input logic clr);
    int k;
    k = lookup(code);
    m_wrap = 0;
    if (m_st == M_SYNC) begin
      if (k >= 0) begin m_st = M_LOCK; m_idx = k; end
    end else if (m_st == M_LOCK) begin
      if (k < 0) begin
        m_st = M_ERR; m_ill = 1;
      end else if (k == (m_idx + 1) % 8) begin
        if (m_idx == 7) begin m_wrap = 1; m_rot = (m_rot + 1) % 256; end
        m_idx = k;
      end else if (k != m_idx) begin
        m_st = M_ERR; m_step = 1;
      end
    end else if (clr) begin
      m_st = M_SYNC; m_ill = 0; m_step = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int ev;
    ev = (m_st == M_LOCK) ? 1 : 0;
    chk({tag, ".phase_idx"}, phase_idx, m_idx);
    chk({tag, ".phase_oh"}, phase_oh, ev ? (1 << m_idx) : 0);
    chk({tag, ".valid"}, valid, ev);
    chk({tag, ".wrap"}, wrap, m_wrap);
    chk({tag, ".rot_cnt"}, rot_cnt, m_rot);
    chk({tag, ".err_illegal"}, err_illegal, m_ill);
    chk({tag, ".err_step"}, err_step, m_step);
  endtask

  task automatic step(input logic [3:0] code, input logic clr);
    @(negedge clk);
    jc_in = code;
    err_clr = clr;
    @(posedge clk);
    model_update(code, clr);
    #1 check_all("cyc");
  endtask

  // Async reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("rst");
    chk("rst.valid_lit", valid, 0);
    chk("rst.phase_oh_lit", phase_oh, 0);
    chk("rst.rot_cnt_lit", rot_cnt, 0);
    chk("rst.err_step_lit", err_step, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    jc_in = 4'b0000;
    err_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // One full rotation from reset.
    step(4'b0000, 1'b0);
    chk("lock.valid_lit", valid, 1);
    chk("lock.phase_oh_lit", phase_oh, 8'h01);
    for (int i = 1; i < 9; i++) step(tab[i % 8], 1'b0);
    chk("rot1.idx_lit", phase_idx, 0);
    chk("rot1.rot_cnt_lit", rot_cnt, 1);
    chk("rot1.valid_lit", valid, 1);

    // Illegal code while locked at idx 3, clear, relock at idx 4.
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0111, 1'b0);
    step(4'b0101, 1'b0);
    chk("ill.err_illegal_lit", err_illegal, 1);
    chk("ill.valid_lit", valid, 0);
    chk("ill.phase_oh_lit", phase_oh, 0);
    chk("ill.idx_hold_lit", phase_idx, 3);
    step(4'b1111, 1'b1);
    chk("clr.valid_lit", valid, 0);
    chk("clr.err_illegal_lit", err_illegal, 0);
    step(4'b1111, 1'b0);
    chk("relock.idx_lit", phase_idx, 4);
    chk("relock.valid_lit", valid, 1);

    // Stall must not flag; skip 2->4 must flag err_step only.
    for (int i = 5; i < 11; i++) step(tab[i % 8], 1'b0);
    step(4'b0011, 1'b0);
    chk("stall.err_step_lit", err_step, 0);
    chk("stall.idx_lit", phase_idx, 2);
    step(4'b1111, 1'b0);
    chk("skip.err_step_lit", err_step, 1);
    chk("skip.err_illegal_lit", err_illegal, 0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Rotation counter wraps modulo 256.
    do_reset();
    step(4'b0000, 1'b0);
    for (int r = 0; r < 256; r++)
      for (int i = 1; i < 9; i++) step(tab[i % 8], 1'b0);
    chk("r256.rot_cnt_lit", rot_cnt, 0);
    chk("r256.wrap_lit", wrap, 1);
    for (int i = 1; i < 9; i++) step(tab[i % 8], 1'b0);
    chk("r257.rot_cnt_lit", rot_cnt, 1);

    // Reach idx 5, step backwards into ERROR, then reset mid-rotation.
    for (int i = 1; i < 6; i++) step(tab[i], 1'b0);
    step(4'b0011, 1'b0);
    chk("back.err_step_lit", err_step, 1);
    chk("back.idx_hold_lit", phase_idx, 5);
    do_reset();
    step(4'b0000, 1'b0);
    chk("post.idx_lit", phase_idx, 0);
    chk("post.valid_lit", valid, 1);
    chk("post.err_step_lit", err_step, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
